// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer
//   Frame-synchronous rule controller for the cellular-automaton VGA engine.
//   Holds a 4-entry table of Wolfram rule codes and chooses the active rule,
//   when the engine reseeds and whether it advances. Rules auto-cycle every
//   FRAMES_PER_RULE frames. Debounced "next" and "pause" buttons can also
//   change the rule or freeze the image. Every output is registered and only
//   changes on the clock edge that samples frame_start, so the picture never
//   tears mid-frame.
//
// Ports
//   clk         pixel clock
//   rst_n       asynchronous active-low reset (release synchronised internally)
//   frame_start one-cycle pulse at first pixel of row 0
//   btn_next    raw button, press selects the next rule
//   btn_pause   raw button, press toggles pause
//   cfg_we      rule-table write strobe
//   cfg_idx     rule-table write address
//   cfg_data    rule code to write
//   rule        active Wolfram code for the current frame
//   rule_idx    index of the active rule
//   seed_load   engine loads a single-centre-cell seed this frame
//   advance     engine computes new generations this frame
//   paused      pause state
//   frame_cnt   frames elapsed under the current rule
module ca_rule_sequencer #(
  parameter int FRAMES_PER_RULE = 240,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_RESEED     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       cfg_we,
  input  logic [1:0] cfg_idx,
  input  logic [7:0] cfg_data,
  output logic [7:0] rule,
  output logic [1:0] rule_idx,
  output logic       seed_load,
  output logic       advance,
  output logic       paused,
  output logic [7:0] frame_cnt
);

  localparam int             CW       = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]     CNT_WRAP = 8'(FRAMES_PER_RULE - 1);
  localparam logic           RESEED_ON_AUTO = (AUTO_RESEED != 0);

  typedef enum logic [1:0] {ST_SEED, ST_RUN, ST_PAUSE} state_t;

  // Reset: asserts immediately, releases two clocks after rst_n rises.
  logic rst_meta, rst_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // Button path: bit 0 = next, bit 1 = pause.
  logic [1:0]         btn_raw, sync1, sync2, deb, rise;
  logic [1:0][CW-1:0] deb_cnt;
  logic               next_pend, pause_pend;

  assign btn_raw = {btn_pause, btn_next};

  // A rising edge is the cycle the debounced level is about to flip 0->1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rise[i] = sync2[i] & ~deb[i] & (deb_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Sticky request flags. A flag raised on the same edge as frame_start was
  // not seen by that boundary, so setting wins over clearing.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      next_pend  <= 1'b0;
      pause_pend <= 1'b0;
    end else begin
      next_pend  <= rise[0] | (next_pend  & ~frame_start);
      pause_pend <= rise[1] | (pause_pend & ~frame_start);
    end
  end

  // Rule table and frame-boundary state
  logic [7:0] rule_tbl [4];
  state_t     state, nxt_state;
  logic [1:0] nxt_idx;
  logic [7:0] nxt_cnt, nxt_rule;
  logic       nxt_seed, nxt_adv;

  always_comb begin
    nxt_state = state;
    nxt_idx   = rule_idx;
    nxt_cnt   = frame_cnt;
    nxt_seed  = seed_load;
    nxt_adv   = advance;
    if (frame_start) begin
      if (state == ST_SEED) begin
        nxt_seed  = 1'b1;
        nxt_cnt   = 8'd0;
        nxt_state = pause_pend ? ST_PAUSE : ST_RUN;
      end else begin
        if (pause_pend) begin
          nxt_state = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
        nxt_seed = 1'b0;
        // A button press and an auto-advance on the same boundary step once.
        if (next_pend) begin
          nxt_idx  = rule_idx + 2'd1;
          nxt_cnt  = 8'd0;
          nxt_seed = 1'b1;
        end else if (state == ST_RUN) begin
          if (frame_cnt == CNT_WRAP) begin
            nxt_idx  = rule_idx + 2'd1;
            nxt_cnt  = 8'd0;
            nxt_seed = RESEED_ON_AUTO;
          end else begin
            nxt_cnt = frame_cnt + 8'd1;
          end
        end
      end
      // A seeded frame must run so the seed row is drawn even while paused.
      nxt_adv = nxt_seed | (nxt_state == ST_RUN);
    end
    // Write-first: a table write on the boundary edge is what gets shown.
    nxt_rule = (cfg_we && (cfg_idx == nxt_idx)) ? cfg_data : rule_tbl[nxt_idx];
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      rule_tbl[0] <= 8'd30;
      rule_tbl[1] <= 8'd110;
      rule_tbl[2] <= 8'd90;
      rule_tbl[3] <= 8'd184;
    end else if (cfg_we) begin
      rule_tbl[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= ST_SEED;
      rule      <= 8'd30;
      rule_idx  <= 2'd0;
      seed_load <= 1'b1;
      advance   <= 1'b1;
      paused    <= 1'b0;
      frame_cnt <= 8'd0;
    end else if (frame_start) begin
      state     <= nxt_state;
      rule      <= nxt_rule;
      rule_idx  <= nxt_idx;
      seed_load <= nxt_seed;
      advance   <= nxt_adv;
      paused    <= (nxt_state == ST_PAUSE);
      frame_cnt <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_ca_rule_sequencer.sv
// tb_ca_rule_sequencer
//   Directed bench for ca_rule_sequencer. Two instances share all inputs:
//   dut_a uses FRAMES_PER_RULE=240 (buttons, pause, table writes) and dut_b
//   uses FRAMES_PER_RULE=2 (auto-cycling). Both use DEBOUNCE_CYCLES=4.
module tb_ca_rule_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_pause = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = 2'd0;
  logic [7:0] cfg_data = 8'd0;

  logic [7:0] rule_a, cnt_a, rule_b, cnt_b;
  logic [1:0] idx_a, idx_b;
  logic       seed_a, adv_a, paused_a, seed_b, adv_b, paused_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ca_rule_sequencer #(.FRAMES_PER_RULE(240), .DEBOUNCE_CYCLES(4), .AUTO_RESEED(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .btn_next(btn_next), .btn_pause(btn_pause),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .rule(rule_a), .rule_idx(idx_a), .seed_load(seed_a), .advance(adv_a),
    .paused(paused_a), .frame_cnt(cnt_a)
  );

  ca_rule_sequencer #(.FRAMES_PER_RULE(2), .DEBOUNCE_CYCLES(4), .AUTO_RESEED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .btn_next(btn_next), .btn_pause(btn_pause),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .rule(rule_b), .rule_idx(idx_b), .seed_load(seed_b), .advance(adv_b),
    .paused(paused_b), .frame_cnt(cnt_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
  endtask

  // One-cycle frame_start pulse; outputs are sampled at the following negedge.
  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic press_next(input int n);
    @(negedge clk);
    btn_next = 1'b1;
    idle(n);
    btn_next = 1'b0;
    idle(20);
  endtask

  task automatic press_pause(input int n);
    @(negedge clk);
    btn_pause = 1'b1;
    idle(n);
    btn_pause = 1'b0;
    idle(20);
  endtask

  // Auto-cycling expectations for FRAMES_PER_RULE=2
  int exp_idx  [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_rule [9] = '{30, 30, 110, 110, 90, 90, 184, 184, 30};
  int exp_seed [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    // Reset values
    idle(3);
    chk("rst_rule", rule_a, 30);
    chk("rst_idx", idx_a, 0);
    chk("rst_seed", seed_a, 1);
    chk("rst_adv", adv_a, 1);
    chk("rst_paused", paused_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst_n = 1'b1;
    idle(4);

    // Three frames, FRAMES_PER_RULE=240
    frame();
    chk("f1_seed", seed_a, 1);
    chk("f1_rule", rule_a, 30);
    chk("f1_cnt", cnt_a, 0);
    chk("f1_adv", adv_a, 1);
    idle(10);
    for (int f = 2; f <= 3; f++) begin
      frame();
      chk("fN_seed", seed_a, 0);
      chk("fN_adv", adv_a, 1);
      chk("fN_cnt", cnt_a, f - 1);
      idle(10);
    end

    // Auto-cycling, FRAMES_PER_RULE=2
    do_reset();
    for (int f = 0; f < 9; f++) begin
      frame();
      chk($sformatf("auto%0d_idx", f), idx_b, exp_idx[f]);
      chk($sformatf("auto%0d_rule", f), rule_b, exp_rule[f]);
      chk($sformatf("auto%0d_seed", f), seed_b, exp_seed[f]);
      idle(10);
    end

    // Debounce: glitch rejected, real press steps once
    do_reset();
    frame();
    idle(5);
    press_next(3);
    frame();
    chk("glitch_idx", idx_a, 0);
    chk("glitch_seed", seed_a, 0);
    chk("glitch_cnt", cnt_a, 1);
    idle(5);
    press_next(10);
    idle(5);
    chk("press_pre_idx", idx_a, 0);
    frame();
    chk("press_idx", idx_a, 1);
    chk("press_rule", rule_a, 110);
    chk("press_seed", seed_a, 1);
    chk("press_cnt", cnt_a, 0);
    idle(10);
    frame();
    chk("press_once_idx", idx_a, 1);
    chk("press_once_seed", seed_a, 0);
    chk("press_once_cnt", cnt_a, 1);

    // Pause: the boundary that enters pause still counts the RUN frame
    idle(5);
    press_pause(10);
    frame();
    chk("pause_paused", paused_a, 1);
    chk("pause_adv", adv_a, 0);
    chk("pause_cnt", cnt_a, 2);
    for (int f = 0; f < 2; f++) begin
      idle(10);
      frame();
      chk("pause_hold_cnt", cnt_a, 2);
      chk("pause_hold_adv", adv_a, 0);
    end
    idle(5);
    press_next(10);
    frame();
    chk("pnext_idx", idx_a, 2);
    chk("pnext_rule", rule_a, 90);
    chk("pnext_seed", seed_a, 1);
    chk("pnext_adv", adv_a, 1);
    chk("pnext_paused", paused_a, 1);
    chk("pnext_cnt", cnt_a, 0);
    idle(10);
    frame();
    chk("pnext2_adv", adv_a, 0);
    chk("pnext2_seed", seed_a, 0);
    idle(5);
    press_pause(10);
    frame();
    chk("resume_paused", paused_a, 0);
    chk("resume_adv", adv_a, 1);
    chk("resume_cnt", cnt_a, 0);
    idle(10);
    frame();
    chk("resume2_cnt", cnt_a, 1);

    // Table writes: hidden until frame_start, write-first on the boundary
    do_reset();
    frame();
    idle(5);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = 8'h96;
    @(negedge clk);
    cfg_we = 1'b0;
    idle(5);
    chk("cfg_hidden_rule", rule_a, 30);
    frame();
    chk("cfg_shown_rule", rule_a, 8'h96);
    idle(5);
    @(negedge clk);
    frame_start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = 8'h55;
    @(negedge clk);
    frame_start = 1'b0; cfg_we = 1'b0;
    chk("cfg_wfirst_rule", rule_a, 8'h55);

    // Coincident next press and auto-advance, then async reset mid-frame
    do_reset();
    frame();
    idle(5);
    frame();
    chk("coin_pre_cnt", cnt_b, 1);
    idle(5);
    press_next(10);
    frame();
    chk("coin_idx", idx_b, 1);
    chk("coin_rule", rule_b, 110);
    chk("coin_seed", seed_b, 1);
    chk("coin_cnt", cnt_b, 0);
    idle(5);
    frame();
    chk("coin2_seed", seed_b, 0);
    chk("coin2_cnt", cnt_b, 1);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rule", rule_b, 30);
    chk("arst_idx", idx_b, 0);
    chk("arst_seed", seed_b, 1);
    chk("arst_cnt", cnt_b, 0);
    chk("arst_adv", adv_b, 1);
    idle(3);
    rst_n = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
